// File: rtl/mfda_seq_pkg.sv
`default_nettype none
// ============================================================================
// mfda_seq_pkg : shared types and default constants for the assay sequencer
// Rev 1.0
// ============================================================================
package mfda_seq_pkg;

  localparam int DEF_NUM_STAGES     = 4;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_SETTLE_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    STG_BYPASS = 2'd0,
    STG_MIXER  = 2'd1,
    STG_HEATER = 2'd2,
    STG_FILTER = 2'd3
  } stage_type_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_ERROR   = 3'd5
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/assay_stage_sequencer_stage_timer.sv
`default_nettype none
// ============================================================================
// stage_timer : loadable saturating down-counter shared by SETTLE and DWELL
// Rev 1.0
// ============================================================================
module stage_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Done on the last counted cycle, so a load of N spans exactly N cycles.
  assign done = (count <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/assay_stage_sequencer.sv
`default_nettype none
// ============================================================================
// assay_stage_sequencer : programmable fluidic stage sequencer with heater settle
// Rev 1.0
// ============================================================================
module assay_stage_sequencer
  import mfda_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int SETTLE_TIMEOUT = DEF_SETTLE_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_STAGES)-1:0] cfg_addr,
  input  logic [1:0]                    cfg_type,
  input  logic [CNT_W-1:0]              cfg_dwell,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic                          heat_ok,
  input  logic                          abort,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          busy,
  output logic                          err
);

  localparam int                IDX_W       = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_TIMEOUT);

  seq_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  stage_type_e      type_tbl  [NUM_STAGES];
  logic [CNT_W-1:0] dwell_tbl [NUM_STAGES];

  stage_type_e      cur_type;
  logic [CNT_W-1:0] cur_dwell;
  logic [CNT_W-1:0] dwell_load;
  logic             addr_ok;

  logic             tmr_clr, tmr_load, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  if (2 ** IDX_W == NUM_STAGES) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (32'(cfg_addr) < NUM_STAGES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        type_tbl[i]  <= STG_BYPASS;
        dwell_tbl[i] <= '0;
      end
    end else if (cfg_we && !busy && addr_ok) begin
      type_tbl[cfg_addr]  <= stage_type_e'(cfg_type);
      dwell_tbl[cfg_addr] <= cfg_dwell;
    end
  end

  assign cur_type   = type_tbl[idx];
  assign cur_dwell  = dwell_tbl[idx];
  // A zero dwell still holds the stage for one cycle.
  assign dwell_load = (cur_dwell == '0) ? CNT_W'(1) : cur_dwell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = dwell_load;
    unique case (state)
      ST_IDLE: begin
        if (src_valid && src_ready) begin
          state_nxt = ST_ADVANCE;
          idx_nxt   = '0;
        end
      end
      ST_ADVANCE: begin
        unique case (cur_type)
          STG_BYPASS: begin
            if (idx == LAST_IDX) state_nxt = ST_DRAIN;
            else                 idx_nxt   = idx + 1'b1;
          end
          STG_HEATER: begin
            state_nxt = ST_SETTLE;
            tmr_load  = 1'b1;
            tmr_val   = SETTLE_LOAD;
          end
          default: begin
            state_nxt = ST_DWELL;
            tmr_load  = 1'b1;
          end
        endcase
      end
      ST_SETTLE: begin
        if (heat_ok) begin
          state_nxt = ST_DWELL;
          tmr_load  = 1'b1;
        end else if (tmr_done) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_DWELL: begin
        if (tmr_done) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_ADVANCE;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      tmr_clr   = 1'b1;
    end
  end

  assign tmr_en = (state == ST_SETTLE) || (state == ST_DWELL);

  stage_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // Handshakes are gated by abort so a simultaneous abort never completes a transfer.
  assign src_ready = rst_n && (state == ST_IDLE) && !abort;
  assign out_valid = (state == ST_DRAIN) && !abort;
  assign busy      = (state != ST_IDLE);
  assign err       = (state == ST_ERROR);
  assign stage_idx = idx;
  assign stage_en  = tmr_en ? ({{(NUM_STAGES-1){1'b0}}, 1'b1} << idx) : '0;

endmodule
`default_nettype wire

// File: tb/tb_assay_stage_sequencer.sv
`default_nettype none
// ============================================================================
// tb_assay_stage_sequencer : randomized bench against a timeline reference model
// Rev 1.0
// ============================================================================
module tb_assay_stage_sequencer;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [1:0]    cfg_type = '0;
  logic [CW-1:0] cfg_dwell = '0;
  logic          src_valid = 1'b0;
  logic          heat_ok = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          src_ready, out_valid, busy, err;
  logic [N-1:0]  stage_en;
  logic [1:0]    stage_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int m_type  [N];
  int m_dwell [N];
  bit heat    [512];
  int q_en    [$];
  int q_idx   [$];
  bit m_err;

  assay_stage_sequencer #(
    .NUM_STAGES     (N),
    .CNT_W          (CW),
    .SETTLE_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_type  (cfg_type),
    .cfg_dwell (cfg_dwell),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .heat_ok   (heat_ok),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stage_en  (stage_en),
    .stage_idx (stage_idx),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic program_stage(input int s, input int typ, input int dw);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(s);
    cfg_type  = 2'(typ);
    cfg_dwell = CW'(dw);
    @(negedge clk);
    cfg_we    = 1'b0;
    m_type[s]  = typ;
    m_dwell[s] = dw;
  endtask

  task automatic set_heat(input int mode);
    for (int i = 0; i < 512; i++)
      heat[i] = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
  endtask

  // Timeline of expected per-cycle stage_en/stage_idx, cycle 1 = first cycle after acceptance.
  task automatic build_model();
    q_en.delete();
    q_idx.delete();
    m_err = 1'b0;
    for (int s = 0; s < N; s++) begin
      q_en.push_back(0);
      q_idx.push_back(s);
      if (m_type[s] == 0) continue;
      if (m_type[s] == 2) begin
        int  k;
        bit  hot;
        k   = 0;
        hot = 1'b0;
        while (!hot && k < TO) begin
          k++;
          hot = heat[q_en.size() + 1];
          q_en.push_back(1 << s);
          q_idx.push_back(s);
        end
        if (!hot) begin
          m_err = 1'b1;
          return;
        end
      end
      repeat ((m_dwell[s] == 0) ? 1 : m_dwell[s]) begin
        q_en.push_back(1 << s);
        q_idx.push_back(s);
      end
    end
  endtask

  task automatic run_case(input int exp_lat, input bit drain_abort, input int drain_wait,
                          input bit busy_write);
    int t;
    int lat_seen;
    build_model();
    @(negedge clk);
    chk("src_ready_idle", src_ready, 1);
    src_valid = 1'b1;
    @(negedge clk);
    src_valid = 1'b0;
    lat_seen  = -1;
    t = 1;
    while (t <= q_en.size()) begin
      chk("stage_en", stage_en, q_en[t-1]);
      chk("stage_idx", stage_idx, q_idx[t-1]);
      chk("busy_run", busy, 1);
      if ((out_valid || err) && lat_seen < 0) lat_seen = t - 1;
      heat_ok = heat[t];
      if (busy_write && t == 2) begin
        cfg_we    = 1'b1;
        cfg_addr  = 2'($urandom_range(0, N-1));
        cfg_type  = 2'($urandom);
        cfg_dwell = CW'(9);
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    cfg_we = 1'b0;
    if ((out_valid || err) && lat_seen < 0) lat_seen = t - 1;
    chk("latency", lat_seen, (exp_lat >= 0) ? exp_lat : q_en.size());
    if (m_err) begin
      chk("err_set", err, 1);
      repeat (3) begin
        chk("err_src_ready", src_ready, 0);
        chk("err_stage_en", stage_en, 0);
        chk("err_busy", busy, 1);
        chk("err_out_valid", out_valid, 0);
        @(negedge clk);
      end
      chk("err_sticky", err, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_err_clr", err, 0);
      chk("abort_busy", busy, 0);
      chk("abort_src_ready", src_ready, 1);
    end else if (drain_abort) begin
      chk("drain_valid", out_valid, 1);
      out_ready = 1'b1;
      abort     = 1'b1;
      #1;
      chk("drain_abort_ov", out_valid, 0);
      @(negedge clk);
      abort     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("drain_abort_busy", busy, 0);
      chk("drain_abort_idx", stage_idx, 0);
      chk("drain_abort_ov2", out_valid, 0);
    end else begin
      for (int w = 0; w <= drain_wait; w++) begin
        chk("drain_valid", out_valid, 1);
        chk("drain_stage_en", stage_en, 0);
        chk("drain_busy", busy, 1);
        if (w < drain_wait) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("done_busy", busy, 0);
      chk("done_out_valid", out_valid, 0);
      chk("done_src_ready", src_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_type[i]  = 0;
      m_dwell[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_src_ready", src_ready, 1);
    chk("post_rst_idx", stage_idx, 0);

    // Default table: everything bypassed, outlet reached after one ADVANCE per stage.
    set_heat(1);
    run_case(N, 1'b0, 0, 1'b0);

    // Mixed table with heater that settles immediately.
    program_stage(0, 1, 3);
    program_stage(1, 2, 5);
    program_stage(2, 3, 2);
    program_stage(3, 1, 1);
    run_case(16, 1'b0, 0, 1'b0);

    // Stage 1 bypassed; writes while busy must not change this or the next run.
    program_stage(0, 1, 2);
    program_stage(1, 0, 2);
    program_stage(2, 1, 2);
    program_stage(3, 1, 2);
    run_case(10, 1'b0, 5, 1'b1);
    run_case(10, 1'b0, 0, 1'b0);

    // Heater never settles -> sticky error, cleared by abort.
    program_stage(1, 2, 4);
    set_heat(0);
    run_case(-1, 1'b0, 0, 1'b0);

    // Abort together with src_valid in IDLE: sample refused.
    @(negedge clk);
    src_valid = 1'b1;
    abort     = 1'b1;
    #1;
    chk("abort_idle_ready", src_ready, 0);
    @(negedge clk);
    src_valid = 1'b0;
    abort     = 1'b0;
    #1;
    chk("abort_idle_busy", busy, 0);

    // Abort together with out_ready in DRAIN.
    set_heat(1);
    run_case(-1, 1'b1, 0, 1'b0);

    // Reset during DWELL of stage 2.
    for (int s = 0; s < N; s++) program_stage(s, 1, 4);
    @(negedge clk);
    src_valid = 1'b1;
    @(negedge clk);
    src_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (stage_idx == 2'd2 && stage_en != '0) break;
      @(negedge clk);
    end
    chk("reached_stage2", stage_en, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stage_en", stage_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_src_ready", src_ready, 0);
    chk("midrst_idx", stage_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", src_ready, 1);
    for (int c = 0; c < 12; c++) begin
      chk("midrst_no_out", out_valid, 0);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      m_type[i]  = 0;
      m_dwell[i] = 0;
    end
    run_case(N, 1'b0, 0, 1'b0);

    // Randomized tables, heater readiness, outlet back-pressure and busy writes.
    for (int r = 0; r < 30; r++) begin
      for (int s = 0; s < N; s++)
        program_stage(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
      set_heat(2);
      run_case(-1, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/assay_stage_sequencer.md
ASSAY_STAGE_SEQUENCER -- requirements
Module: assay_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of programmable fluidic stages (2..16).
REQ-002 SHALL have parameter CNT_W, default 16, dwell-counter width in bits.
REQ-003 SHALL have parameter SETTLE_TIMEOUT, default 1024, maximum heater settle cycles before error.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  input  1  system clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  cfg_we  input  1  stage-table write strobe
  cfg_addr  input  $clog2(NUM_STAGES)  stage index written
  cfg_type  input  2  stage type (BYPASS=0, MIXER=1, HEATER=2, FILTER=3)
  cfg_dwell  input  CNT_W  stage dwell in cycles
  src_valid  input  1  sample available at source inlet
  src_ready  output  1  sequencer accepts sample
  heat_ok  input  1  heater at temperature
  abort  input  1  synchronous run abort
  out_valid  output  1  processed sample at outlet
  out_ready  input  1  outlet accepts sample
  stage_en  output  NUM_STAGES  one-hot valve/actuator enable of active stage
  stage_idx  output  $clog2(NUM_STAGES)  current stage index
  busy  output  1  run in progress
  err  output  1  sticky settle-timeout error

Function
REQ-005 SHALL hold a stage table of NUM_STAGES entries {type, dwell}; cfg_we writes entry cfg_addr in one cycle; writes while busy=1 SHALL be ignored.
REQ-006 SHALL implement states IDLE, ADVANCE, SETTLE, DWELL, DRAIN, ERROR.
REQ-007 IDLE: src_ready=1 iff err=0; on src_valid&&src_ready, go to ADVANCE with stage_idx=0; busy=1 from next cycle.
REQ-008 ADVANCE (exactly one cycle, stage_en=0): type BYPASS -> next stage's ADVANCE (or DRAIN after last); HEATER -> SETTLE; MIXER/FILTER -> DWELL.
REQ-009 SETTLE: stage_en[stage_idx]=1; heat_ok sampled high -> DWELL next cycle; SETTLE_TIMEOUT cycles without heat_ok -> ERROR.
REQ-010 DWELL: stage_en[stage_idx]=1 for exactly max(cfg_dwell,1) cycles, then ADVANCE with stage_idx+1, or DRAIN after stage NUM_STAGES-1.
REQ-011 DRAIN: out_valid=1, stage_en=0, held stable until out_ready=1; on out_valid&&out_ready return to IDLE, busy=0 next cycle.
REQ-012 ERROR: err=1, all stage_en=0, busy=1, src_ready=0, out_valid=0; exits only via abort or reset.
REQ-013 abort=1 in any state SHALL return to IDLE next cycle, clear counters, err, stage_en, out_valid, stage_idx; stage table retained.
REQ-014 abort simultaneous with out_ready in DRAIN: abort wins, transfer not counted as complete (out_valid drops).
REQ-015 abort simultaneous with src_valid in IDLE: sample not accepted.
REQ-016 stage_en SHALL be one-hot or zero at all times; dwell counter SHALL saturate, never wrap.
REQ-017 Total latency for all-MIXER table: NUM_STAGES + sum(max(dwell,1)) cycles from acceptance to out_valid.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, stage_en=0, stage_idx=0, busy=0, err=0, out_valid=0, src_ready=0 while asserted.
REQ-019 Stage table SHALL reset to all BYPASS, dwell 0; src_ready=1 first cycle after rst_n deasserts.
REQ-020 Reset mid-run SHALL discard the in-flight sample without out_valid.

Structure
REQ-021 Package mfda_seq_pkg SHALL hold stage_type_e, seq_state_e and default parameter constants.
REQ-022 One sub-module stage_timer (loadable saturating down-counter, CNT_W wide, done flag) SHALL serve both DWELL and SETTLE timing.

Verification
REQ-023 Table {MIXER 3, HEATER 5, FILTER 2, MIXER 1}, heat_ok=1 -> stage_en sequence 0001x3,0010x1(settle)+x5,0100x2,1000x1 with one zero cycle between; out_valid at cycle 16.
REQ-024 Stage 1 BYPASS, others MIXER 2 -> stage_en[1] never high; out_valid at cycle 10.
REQ-025 HEATER stage, heat_ok held 0, SETTLE_TIMEOUT=8 -> err=1 after 8 settle cycles, src_ready=0; abort -> err=0, IDLE next cycle.
REQ-026 DRAIN with out_ready=0 for 5 cycles -> out_valid held, stage_en=0; out_ready=1 -> IDLE, src_ready=1 next cycle.
REQ-027 rst_n pulsed low in DWELL of stage 2 -> all outputs zero immediately, no out_valid, table reads back BYPASS/0 behaviour.
REQ-028 cfg_we while busy with cfg_dwell=9 -> current and later runs use original dwell.
